// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: master sequencer FSM states and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Both error responses carry bit 1; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_master_seq.sv
// Single-outstanding AXI4-Lite master: turns a one-cycle request strobe into one
// AXI read or write, with a per-transaction timeout and a registered ack/err pulse.
module axil_master_seq
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic                  busy_o,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  axil_state_e           state_r, state_s;
  logic [15:0]           cnt_r, cnt_s;
  logic                  awvalid_r, awvalid_s, wvalid_r, wvalid_s, bready_r, bready_s;
  logic                  arvalid_r, arvalid_s, rready_r, rready_s;
  logic                  ack_r, ack_s, err_r, err_s, busy_r, busy_s;
  logic [31:0]           rdata_r, rdata_s, wdata_r, wdata_s;
  logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_s, araddr_r, araddr_s;
  logic                  done_s, abort_s;

  // Next-state and next-output logic; a completing response beats the timeout.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    awvalid_s = awvalid_r;
    wvalid_s  = wvalid_r;
    bready_s  = bready_r;
    arvalid_s = arvalid_r;
    rready_s  = rready_r;
    ack_s     = 1'b0;
    err_s     = 1'b0;
    rdata_s   = rdata_r;
    wdata_s   = wdata_r;
    awaddr_s  = awaddr_r;
    araddr_s  = araddr_r;
    done_s    = ((state_r == ST_WR_RESP) && bvalid && bready_r) ||
                ((state_r == ST_RD_RESP) && rvalid && rready_r);
    abort_s   = (state_r != ST_IDLE) && !done_s && (cnt_r == TMO_LAST);

    if (state_r != ST_IDLE) begin
      cnt_s = cnt_r + 16'd1;
    end else begin
      cnt_s = 16'd0;
    end

    if (abort_s) begin
      state_s   = ST_IDLE;
      awvalid_s = 1'b0;
      wvalid_s  = 1'b0;
      bready_s  = 1'b0;
      arvalid_s = 1'b0;
      rready_s  = 1'b0;
      ack_s     = 1'b1;
      err_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // busy_r is still high during the ack cycle, so a request there is dropped.
          if (req_i && !busy_r) begin
            if (we_i) begin
              state_s   = ST_WR_REQ;
              awvalid_s = 1'b1;
              wvalid_s  = 1'b1;
              awaddr_s  = addr_i;
              wdata_s   = wdata_i;
            end else begin
              state_s   = ST_RD_REQ;
              arvalid_s = 1'b1;
              araddr_s  = addr_i;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          awvalid_s = awvalid_r & ~awready;
          wvalid_s  = wvalid_r & ~wready;
          if (!awvalid_s && !wvalid_s) begin
            state_s  = ST_WR_RESP;
            bready_s = 1'b1;
          end else begin
            state_s = ST_WR_REQ;
          end
        end
        ST_WR_RESP: begin
          if (done_s) begin
            state_s  = ST_IDLE;
            bready_s = 1'b0;
            ack_s    = 1'b1;
            err_s    = resp_is_err(bresp);
          end else begin
            state_s = ST_WR_RESP;
          end
        end
        ST_RD_REQ: begin
          if (arready) begin
            state_s   = ST_RD_RESP;
            arvalid_s = 1'b0;
            rready_s  = 1'b1;
          end else begin
            state_s = ST_RD_REQ;
          end
        end
        ST_RD_RESP: begin
          if (done_s) begin
            state_s  = ST_IDLE;
            rready_s = 1'b0;
            rdata_s  = rdata;
            ack_s    = 1'b1;
            err_s    = resp_is_err(rresp);
          end else begin
            state_s = ST_RD_RESP;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          awvalid_s = 1'b0;
          wvalid_s  = 1'b0;
          bready_s  = 1'b0;
          arvalid_s = 1'b0;
          rready_s  = 1'b0;
        end
      endcase
    end

    busy_s = (state_s != ST_IDLE) || ack_s;
  end

  // State and registered-output update.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      rdata_r   <= 32'd0;
      wdata_r   <= 32'd0;
      awaddr_r  <= '0;
      araddr_r  <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      awvalid_r <= awvalid_s;
      wvalid_r  <= wvalid_s;
      bready_r  <= bready_s;
      arvalid_r <= arvalid_s;
      rready_r  <= rready_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
      rdata_r   <= rdata_s;
      wdata_r   <= wdata_s;
      awaddr_r  <= awaddr_s;
      araddr_r  <= araddr_s;
    end
  end

  assign ack_o   = ack_r;
  assign err_o   = err_r;
  assign rdata_o = rdata_r;
  assign busy_o  = busy_r;
  assign awvalid = awvalid_r;
  assign awaddr  = awaddr_r;
  assign awprot  = 3'b000;
  assign wvalid  = wvalid_r;
  assign wdata   = wdata_r;
  assign wstrb   = 4'b1111;
  assign bready  = bready_r;
  assign arvalid = arvalid_r;
  assign araddr  = araddr_r;
  assign arprot  = 3'b000;
  assign rready  = rready_r;

endmodule

// File: tb/tb_axil_master_seq.sv
// Directed bench for axil_master_seq: configurable AXI4-Lite slave model plus an
// ack scoreboard that checks err/rdata and the exact completion cycle.
module tb_axil_master_seq;
  import axil_pkg::*;

  localparam int AW  = 8;
  localparam int TMO = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i;
  logic          ack_o, err_o, busy_o;
  logic [31:0]   rdata_o;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  always #5 aclk = ~aclk;

  axil_master_seq #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int          aw_delay, w_delay, ar_delay, r_delay;
  bit          ar_never, b_hold, rdata_ovr;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;

  int          aw_cnt, w_cnt, ar_cnt, r_wait, aw_txn, ar_txn;
  bit          aw_done, w_done, b_pending, r_pending;
  logic [7:0]  aw_addr_l;
  logic [31:0] w_data_l, r_data_l;
  logic [1:0]  r_resp_l;
  logic [31:0] mem [256];

  assign awready = awvalid && !aw_done && (aw_cnt == aw_delay);
  assign wready  = wvalid && !w_done && (w_cnt == w_delay);
  assign bvalid  = b_pending && !b_hold;
  assign bresp   = bresp_cfg;
  assign arready = arvalid && !ar_never && !r_pending && (ar_cnt == ar_delay);
  assign rvalid  = r_pending && (r_wait == 0);
  assign rdata   = r_data_l;
  assign rresp   = r_resp_l;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_wait <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; b_pending <= 1'b0; r_pending <= 1'b0;
      aw_addr_l <= 8'd0; w_data_l <= 32'd0; r_data_l <= 32'd0; r_resp_l <= 2'b00;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin
        aw_done <= 1'b1; aw_addr_l <= awaddr; aw_txn <= aw_txn + 1;
      end
      if (wvalid && wready) begin
        w_done <= 1'b1; w_data_l <= wdata;
      end
      if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready)) && !b_pending) begin
        b_pending <= 1'b1;
        mem[aw_done ? aw_addr_l : awaddr] <= w_done ? w_data_l : wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (bvalid && bready) b_pending <= 1'b0;
      if (arvalid && arready) begin
        r_pending <= 1'b1;
        r_wait    <= r_delay - 1;
        r_data_l  <= rdata_ovr ? rdata_cfg : mem[araddr];
        r_resp_l  <= rresp_cfg;
        ar_txn    <= ar_txn + 1;
      end else if (r_pending && (r_wait != 0)) begin
        r_wait <= r_wait - 1;
      end
      if (rvalid && rready) r_pending <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          chk_rd;
    bit          err;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  exp_t e;
  always @(negedge aclk) begin
    if (!areset && ack_o) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL spurious_ack: observed ack at cycle %0d expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32("ack_cycle", cyc, e.ack_cyc);
        check1("ack_err", err_o, e.err);
        check1("ack_busy", busy_o, 1'b1);
        if (e.chk_rd) check32("ack_rdata", rdata_o, e.rdata);
      end
    end
  end

  // lat = cycles from the req_i cycle to the ack_o cycle
  task automatic issue(input bit we, input logic [7:0] a, input logic [31:0] d, input bit push,
                       input bit chk_rd, input bit exp_err, input logic [31:0] exp_rd, input int lat);
    @(posedge aclk); #1;
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    if (push) exp_q.push_back('{chk_rd: chk_rd, err: exp_err, rdata: exp_rd, ack_cyc: cyc + lat});
    @(posedge aclk); #1;
    req_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge aclk);
      n++;
    end
    check32({tag, "_drain"}, exp_q.size(), 32'd0);
    @(posedge aclk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_awvalid"}, awvalid, 1'b0);
    check1({tag, "_wvalid"}, wvalid, 1'b0);
    check1({tag, "_bready"}, bready, 1'b0);
    check1({tag, "_arvalid"}, arvalid, 1'b0);
    check1({tag, "_rready"}, rready, 1'b0);
    check1({tag, "_ack"}, ack_o, 1'b0);
    check1({tag, "_err"}, err_o, 1'b0);
    check1({tag, "_busy"}, busy_o, 1'b0);
    check32({tag, "_rdata_o"}, rdata_o, 32'd0);
    check32({tag, "_wdata"}, wdata, 32'd0);
    check32({tag, "_awaddr"}, {24'd0, awaddr}, 32'd0);
    check32({tag, "_araddr"}, {24'd0, araddr}, 32'd0);
  endtask

  int ar0, aw0;

  initial begin
    areset = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = 8'd0; wdata_i = 32'd0;
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 1;
    ar_never = 1'b0; b_hold = 1'b0; rdata_ovr = 1'b0; rdata_cfg = 32'd0;
    bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY; aw_txn = 0; ar_txn = 0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    areset = 1'b0;

    // zero-wait write, then read it back
    issue(1'b1, 8'h00, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'd0, 3);
    check32("wstrb", {28'd0, wstrb}, 32'hF);
    check32("awprot", {29'd0, awprot}, 32'd0);
    drain("wr_zero");
    check32("slave_mem0", mem[0], 32'hDEADBEEF);
    issue(1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 3);
    check32("arprot", {29'd0, arprot}, 32'd0);
    drain("rd_back");

    // wready four cycles after awready
    w_delay = 4;
    issue(1'b1, 8'h10, 32'hA5A50001, 1'b1, 1'b0, 1'b0, 32'd0, 7);
    @(posedge aclk); #1;
    check1("split_awvalid_dropped", awvalid, 1'b0);
    check1("split_wvalid_held", wvalid, 1'b1);
    @(posedge aclk); @(posedge aclk); #1;
    check1("split_wvalid_held2", wvalid, 1'b1);
    check32("split_wdata_stable", wdata, 32'hA5A50001);
    drain("wr_split");
    w_delay = 0;

    // delayed SLVERR read
    r_delay = 2; rdata_ovr = 1'b1; rdata_cfg = 32'h12345678; rresp_cfg = RESP_SLVERR;
    issue(1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 1'b1, 32'h12345678, 4);
    drain("rd_slverr");
    r_delay = 1; rdata_ovr = 1'b0; rresp_cfg = RESP_OKAY;

    // DECERR write
    bresp_cfg = RESP_DECERR;
    issue(1'b1, 8'h20, 32'h0000FFFF, 1'b1, 1'b0, 1'b1, 32'd0, 3);
    drain("wr_decerr");
    bresp_cfg = RESP_OKAY;

    // slow arready
    ar_delay = 2;
    issue(1'b0, 8'h10, 32'd0, 1'b1, 1'b1, 1'b0, 32'hA5A50001, 5);
    drain("rd_slow_ar");
    ar_delay = 0;

    // arready never comes: timeout after TMO busy cycles
    ar_never = 1'b1;
    issue(1'b0, 8'h30, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, TMO + 1);
    drain("rd_timeout");
    check1("timeout_arvalid_low", arvalid, 1'b0);
    check1("timeout_busy_low", busy_o, 1'b0);
    ar_never = 1'b0;

    // requests while busy and in the ack cycle are ignored
    ar0 = ar_txn; aw0 = aw_txn;
    issue(1'b1, 8'h04, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 32'd0, 3);
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h40;
    @(posedge aclk); #1;
    req_i = 1'b0;
    @(posedge aclk); #1;
    check1("ackcycle_ack", ack_o, 1'b1);
    req_i = 1'b1;
    @(posedge aclk); #1;
    req_i = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    drain("busy_ignore");
    check32("busy_no_read_txn", ar_txn, ar0);
    check32("busy_one_write_txn", aw_txn, aw0 + 1);
    check1("busy_idle_after", busy_o, 1'b0);

    // reset while waiting for the write response
    b_hold = 1'b1;
    issue(1'b1, 8'h08, 32'h11112222, 1'b0, 1'b0, 1'b0, 32'd0, 3);
    @(posedge aclk); #1;
    check1("wr_resp_bready", bready, 1'b1);
    areset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge aclk); #1;
    areset = 1'b0; b_hold = 1'b0;
    repeat (12) @(posedge aclk);
    #1;
    check1("midreset_no_ack_busy", busy_o, 1'b0);

    // recovery after reset
    issue(1'b1, 8'h0C, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 32'd0, 3);
    drain("wr_after_reset");
    check32("slave_mem0c", mem[12], 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
